// File: rtl/layer_perf_monitor.sv
// Per-layer performance monitor and network watchdog: snoops the layer FSM handshakes,
// records per-layer cycle counts and types, and flags protocol errors and timeouts.

module layer_perf_monitor #(
  parameter int unsigned NUM_LAYERS     = 29,
  parameter int unsigned LAYER_W        = 6,
  parameter int unsigned TYPE_W         = 3,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               start,
  input  logic               layer_start,
  input  logic               layer_done,
  input  logic [LAYER_W-1:0] layer_id,
  input  logic [TYPE_W-1:0]  layer_type,
  input  logic               net_done,
  input  logic               rd_en,
  input  logic [LAYER_W-1:0] rd_addr,
  output logic               rd_valid,
  output logic               rd_hit,
  output logic [CNT_W-1:0]   rd_cycles,
  output logic [TYPE_W-1:0]  rd_type,
  output logic [CNT_W-1:0]   total_cycles,
  output logic               busy,
  output logic               finished,
  output logic               timeout,
  output logic [2:0]         err
);

  typedef enum logic [1:0] {StIdle, StRun, StDone, StTout} state_e;

  localparam logic [CNT_W-1:0] CntMax      = {CNT_W{1'b1}};
  localparam logic [LAYER_W:0] NumLayersW  = (LAYER_W + 1)'(NUM_LAYERS);
  localparam logic [63:0]      TimeoutLast = 64'(TIMEOUT_CYCLES) - 64'd1;

  state_e              r_state;
  state_e              w_state_next;
  logic [CNT_W-1:0]    r_total;
  logic                r_active;
  logic                r_oor;
  logic [LAYER_W-1:0]  r_id;
  logic [TYPE_W-1:0]   r_type;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_err;
  logic [NUM_LAYERS-1:0] r_valid;
  logic [CNT_W-1:0]    r_tbl_cycles [NUM_LAYERS];
  logic [TYPE_W-1:0]   r_tbl_type   [NUM_LAYERS];
  logic                r_rd_valid;
  logic                r_rd_hit;
  logic [CNT_W-1:0]    r_rd_cycles;
  logic [TYPE_W-1:0]   r_rd_type;

  logic                w_run;
  logic                w_enter_run;
  logic                w_stay_run;
  logic                w_tout_hit;
  logic                w_id_oor;
  logic                w_wr_en;
  logic [CNT_W-1:0]    w_wr_cycles;
  logic                w_rd_hit;
  logic [CNT_W-1:0]    w_rd_cycles;
  logic [TYPE_W-1:0]   w_rd_type;

  assign w_run       = (r_state == StRun);
  assign w_enter_run = !w_run && start;
  assign w_tout_hit  = (TIMEOUT_CYCLES != 0) && (64'(r_total) == TimeoutLast);
  assign w_stay_run  = w_run && (w_state_next == StRun);
  assign w_id_oor    = ({1'b0, layer_id} >= NumLayersW);
  assign w_wr_en     = w_run && layer_done && r_active && !r_oor;
  // Counter holds cycles-1 since open, so the closing cycle adds one.
  assign w_wr_cycles = (r_cnt == CntMax) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StRun: begin
        if (net_done) begin
          w_state_next = StDone;
        end else if (w_tout_hit) begin
          w_state_next = StTout;
        end
      end
      default: begin
        if (start) begin
          w_state_next = StRun;
        end
      end
    endcase
  end

  // The exit edge does not count, so a timeout leaves total at TIMEOUT_CYCLES-1.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_total <= '0;
    end else if (w_enter_run) begin
      r_total <= '0;
    end else if (w_stay_run && (r_total != CntMax)) begin
      r_total <= r_total + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_active <= 1'b0;
      r_oor    <= 1'b0;
      r_id     <= '0;
      r_type   <= '0;
      r_cnt    <= '0;
      r_err    <= '0;
    end else if (w_enter_run) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_err    <= '0;
    end else if (w_run) begin
      if (layer_done && !r_active) begin
        r_err[1] <= 1'b1;
      end
      if (layer_start && r_active && !layer_done) begin
        r_err[0] <= 1'b1;
      end
      if (layer_start && w_id_oor) begin
        r_err[2] <= 1'b1;
      end
      if (net_done && r_active && !layer_done) begin
        r_err[0] <= 1'b1;
      end

      if (!w_stay_run) begin
        r_active <= 1'b0;
      end else if (layer_start) begin
        r_active <= 1'b1;
        r_oor    <= w_id_oor;
        r_id     <= layer_id;
        r_type   <= layer_type;
        r_cnt    <= '0;
      end else if (layer_done) begin
        r_active <= 1'b0;
      end else if (r_active && (r_cnt != CntMax)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_valid <= '0;
    end else if (w_enter_run) begin
      r_valid <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (r_id == LAYER_W'(i)) begin
          r_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Payload is gated by r_valid on read, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (r_id == LAYER_W'(i)) begin
          r_tbl_cycles[i] <= w_wr_cycles;
          r_tbl_type[i]   <= r_type;
        end
      end
    end
  end

  always_comb begin
    w_rd_hit    = 1'b0;
    w_rd_cycles = '0;
    w_rd_type   = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if ((rd_addr == LAYER_W'(i)) && r_valid[i]) begin
        w_rd_hit    = 1'b1;
        w_rd_cycles = r_tbl_cycles[i];
        w_rd_type   = r_tbl_type[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_rd_valid  <= 1'b0;
      r_rd_hit    <= 1'b0;
      r_rd_cycles <= '0;
      r_rd_type   <= '0;
    end else begin
      r_rd_valid  <= rd_en;
      r_rd_hit    <= rd_en && w_rd_hit;
      r_rd_cycles <= rd_en ? w_rd_cycles : '0;
      r_rd_type   <= rd_en ? w_rd_type : '0;
    end
  end

  assign rd_valid     = r_rd_valid;
  assign rd_hit       = r_rd_hit;
  assign rd_cycles    = r_rd_cycles;
  assign rd_type      = r_rd_type;
  assign total_cycles = r_total;
  assign busy         = w_run;
  assign finished     = (r_state == StDone);
  assign timeout      = (r_state == StTout);
  assign err          = r_err;

endmodule

// File: tb/tb_layer_perf_monitor.sv
// Directed bench for layer_perf_monitor: default, short-watchdog and 4-bit-counter instances
// share one stimulus bus; cycle 0 is the first RUN cycle after each start pulse.

module tb_layer_perf_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, layer_start, layer_done, net_done, rd_en;
  logic [5:0] layer_id, rd_addr;
  logic [2:0] layer_type;

  logic        d_rd_valid, d_rd_hit, d_busy, d_finished, d_timeout;
  logic [31:0] d_rd_cycles, d_total;
  logic [2:0]  d_rd_type, d_err;
  logic        w_rd_valid, w_rd_hit, w_busy, w_finished, w_timeout;
  logic [31:0] w_rd_cycles, w_total;
  logic [2:0]  w_rd_type, w_err;
  logic        s_rd_valid, s_rd_hit, s_busy, s_finished, s_timeout;
  logic [3:0]  s_rd_cycles, s_total;
  logic [2:0]  s_rd_type, s_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  layer_perf_monitor u_dut (
    .CLK(clk), .RESETn(rst_n), .start(start), .layer_start(layer_start),
    .layer_done(layer_done), .layer_id(layer_id), .layer_type(layer_type),
    .net_done(net_done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(d_rd_valid),
    .rd_hit(d_rd_hit), .rd_cycles(d_rd_cycles), .rd_type(d_rd_type),
    .total_cycles(d_total), .busy(d_busy), .finished(d_finished), .timeout(d_timeout),
    .err(d_err)
  );

  layer_perf_monitor #(.TIMEOUT_CYCLES(100)) u_wd (
    .CLK(clk), .RESETn(rst_n), .start(start), .layer_start(layer_start),
    .layer_done(layer_done), .layer_id(layer_id), .layer_type(layer_type),
    .net_done(net_done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(w_rd_valid),
    .rd_hit(w_rd_hit), .rd_cycles(w_rd_cycles), .rd_type(w_rd_type),
    .total_cycles(w_total), .busy(w_busy), .finished(w_finished), .timeout(w_timeout),
    .err(w_err)
  );

  layer_perf_monitor #(.CNT_W(4), .TIMEOUT_CYCLES(0)) u_sat (
    .CLK(clk), .RESETn(rst_n), .start(start), .layer_start(layer_start),
    .layer_done(layer_done), .layer_id(layer_id), .layer_type(layer_type),
    .net_done(net_done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(s_rd_valid),
    .rd_hit(s_rd_hit), .rd_cycles(s_rd_cycles), .rd_type(s_rd_type),
    .total_cycles(s_total), .busy(s_busy), .finished(s_finished), .timeout(s_timeout),
    .err(s_err)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_net_done();
    net_done = 1'b1;
    step(1);
    net_done = 1'b0;
  endtask

  task automatic begin_layer(input logic [5:0] id, input logic [2:0] ty);
    layer_start = 1'b1;
    layer_id    = id;
    layer_type  = ty;
    step(1);
    layer_start = 1'b0;
  endtask

  task automatic end_layer();
    layer_done = 1'b1;
    step(1);
    layer_done = 1'b0;
  endtask

  task automatic read_req(input logic [5:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    step(1);
    rd_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; layer_start = 1'b0; layer_done = 1'b0; net_done = 1'b0;
    rd_en = 1'b0; layer_id = '0; rd_addr = '0; layer_type = '0;
    step(2);
    checks++; if (d_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", d_busy); end
    checks++; if (d_finished !== 1'b0) begin failures++; $display("FAIL rst_finished got=%0h exp=0", d_finished); end
    checks++; if (d_timeout !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%0h exp=0", d_timeout); end
    checks++; if (d_err !== 3'b000) begin failures++; $display("FAIL rst_err got=%0h exp=0", d_err); end
    checks++; if (d_total !== 32'd0) begin failures++; $display("FAIL rst_total got=%0d exp=0", d_total); end
    checks++; if (d_rd_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid got=%0h exp=0", d_rd_valid); end
    checks++; if (d_rd_cycles !== 32'd0) begin failures++; $display("FAIL rst_rd_cycles got=%0d exp=0", d_rd_cycles); end
    #2 rst_n = 1'b1;
    step(2);
    checks++; if (d_busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0h exp=0", d_busy); end
  endtask

  task automatic test_basic();
    pulse_start();
    checks++; if (d_busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0h exp=1", d_busy); end
    checks++; if (d_total !== 32'd0) begin failures++; $display("FAIL basic_total0 got=%0d exp=0", d_total); end
    step(2);
    begin_layer(6'd0, 3'd0);
    step(9);
    end_layer();
    step(2);
    checks++; if (d_finished !== 1'b0) begin failures++; $display("FAIL basic_fin_early got=%0h exp=0", d_finished); end
    pulse_net_done();
    checks++; if (d_finished !== 1'b1) begin failures++; $display("FAIL basic_finished got=%0h exp=1", d_finished); end
    checks++; if (d_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_done got=%0h exp=0", d_busy); end
    checks++; if (d_total !== 32'd15) begin failures++; $display("FAIL basic_total got=%0d exp=15", d_total); end
    checks++; if (d_err !== 3'b000) begin failures++; $display("FAIL basic_err got=%0h exp=0", d_err); end
    step(1);
    checks++; if (d_total !== 32'd15) begin failures++; $display("FAIL basic_total_hold got=%0d exp=15", d_total); end
    read_req(6'd0);
    checks++; if (d_rd_valid !== 1'b1) begin failures++; $display("FAIL basic_rd_valid got=%0h exp=1", d_rd_valid); end
    checks++; if (d_rd_hit !== 1'b1) begin failures++; $display("FAIL basic_rd_hit got=%0h exp=1", d_rd_hit); end
    checks++; if (d_rd_cycles !== 32'd10) begin failures++; $display("FAIL basic_rd_cycles got=%0d exp=10", d_rd_cycles); end
    checks++; if (d_rd_type !== 3'd0) begin failures++; $display("FAIL basic_rd_type got=%0d exp=0", d_rd_type); end
    step(1);
    checks++; if (d_rd_valid !== 1'b0) begin failures++; $display("FAIL basic_rd_valid_drop got=%0h exp=0", d_rd_valid); end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    begin_layer(6'd1, 3'd2);
    step(4);
    // Close id 1, open id 2 and read entry 1 all in one cycle.
    layer_done = 1'b1; layer_start = 1'b1; layer_id = 6'd2; layer_type = 3'd1;
    rd_en = 1'b1; rd_addr = 6'd1;
    step(1);
    layer_done = 1'b0; layer_start = 1'b0; rd_en = 1'b0;
    checks++; if (d_rd_valid !== 1'b1) begin failures++; $display("FAIL b2b_rw_valid got=%0h exp=1", d_rd_valid); end
    checks++; if (d_rd_hit !== 1'b0) begin failures++; $display("FAIL b2b_rw_old got=%0h exp=0", d_rd_hit); end
    step(6);
    end_layer();
    pulse_net_done();
    checks++; if (d_err !== 3'b000) begin failures++; $display("FAIL b2b_err got=%0h exp=0", d_err); end
    read_req(6'd1);
    checks++; if (d_rd_hit !== 1'b1) begin failures++; $display("FAIL b2b_e1_hit got=%0h exp=1", d_rd_hit); end
    checks++; if (d_rd_cycles !== 32'd5) begin failures++; $display("FAIL b2b_e1_cycles got=%0d exp=5", d_rd_cycles); end
    checks++; if (d_rd_type !== 3'd2) begin failures++; $display("FAIL b2b_e1_type got=%0d exp=2", d_rd_type); end
    read_req(6'd2);
    checks++; if (d_rd_hit !== 1'b1) begin failures++; $display("FAIL b2b_e2_hit got=%0h exp=1", d_rd_hit); end
    checks++; if (d_rd_cycles !== 32'd7) begin failures++; $display("FAIL b2b_e2_cycles got=%0d exp=7", d_rd_cycles); end
    checks++; if (d_rd_type !== 3'd1) begin failures++; $display("FAIL b2b_e2_type got=%0d exp=1", d_rd_type); end
    read_req(6'd0);
    checks++; if (d_rd_hit !== 1'b0) begin failures++; $display("FAIL b2b_e0_cleared got=%0h exp=0", d_rd_hit); end
    checks++; if (d_rd_cycles !== 32'd0) begin failures++; $display("FAIL b2b_e0_cycles got=%0d exp=0", d_rd_cycles); end
  endtask

  task automatic test_errors();
    pulse_start();
    begin_layer(6'd3, 3'd0);
    step(2);
    begin_layer(6'd4, 3'd1);
    checks++; if (d_err !== 3'b001) begin failures++; $display("FAIL err_overlap got=%0h exp=1", d_err); end
    step(2);
    end_layer();
    checks++; if (d_err !== 3'b001) begin failures++; $display("FAIL err_close_ok got=%0h exp=1", d_err); end
    end_layer();
    checks++; if (d_err !== 3'b011) begin failures++; $display("FAIL err_orphan got=%0h exp=3", d_err); end
    begin_layer(6'd40, 3'd3);
    step(1);
    end_layer();
    checks++; if (d_err !== 3'b111) begin failures++; $display("FAIL err_range got=%0h exp=7", d_err); end
    read_req(6'd40);
    checks++; if (d_rd_valid !== 1'b1) begin failures++; $display("FAIL err_e40_valid got=%0h exp=1", d_rd_valid); end
    checks++; if (d_rd_hit !== 1'b0) begin failures++; $display("FAIL err_e40_hit got=%0h exp=0", d_rd_hit); end
    checks++; if (d_rd_cycles !== 32'd0) begin failures++; $display("FAIL err_e40_cycles got=%0d exp=0", d_rd_cycles); end
    read_req(6'd3);
    checks++; if (d_rd_hit !== 1'b0) begin failures++; $display("FAIL err_e3_hit got=%0h exp=0", d_rd_hit); end
    read_req(6'd4);
    checks++; if (d_rd_hit !== 1'b1) begin failures++; $display("FAIL err_e4_hit got=%0h exp=1", d_rd_hit); end
    checks++; if (d_rd_cycles !== 32'd3) begin failures++; $display("FAIL err_e4_cycles got=%0d exp=3", d_rd_cycles); end
    pulse_net_done();
    checks++; if (d_err !== 3'b111) begin failures++; $display("FAIL err_sticky got=%0h exp=7", d_err); end
  endtask

  task automatic test_watchdog();
    pulse_start();
    begin_layer(6'd5, 3'd0);
    step(2);
    end_layer();
    end_layer();
    checks++; if (w_err !== 3'b010) begin failures++; $display("FAIL wd_err got=%0h exp=2", w_err); end
    step(94);
    checks++; if (w_timeout !== 1'b0) begin failures++; $display("FAIL wd_early got=%0h exp=0", w_timeout); end
    checks++; if (w_total !== 32'd99) begin failures++; $display("FAIL wd_total99 got=%0d exp=99", w_total); end
    step(1);
    checks++; if (w_timeout !== 1'b1) begin failures++; $display("FAIL wd_timeout got=%0h exp=1", w_timeout); end
    checks++; if (w_busy !== 1'b0) begin failures++; $display("FAIL wd_busy got=%0h exp=0", w_busy); end
    checks++; if (w_finished !== 1'b0) begin failures++; $display("FAIL wd_finished got=%0h exp=0", w_finished); end
    checks++; if (w_total !== 32'd99) begin failures++; $display("FAIL wd_total got=%0d exp=99", w_total); end
    checks++; if (d_busy !== 1'b1) begin failures++; $display("FAIL wd_dflt_busy got=%0h exp=1", d_busy); end
    read_req(6'd5);
    checks++; if (w_rd_hit !== 1'b1) begin failures++; $display("FAIL wd_e5_hit got=%0h exp=1", w_rd_hit); end
    checks++; if (w_rd_cycles !== 32'd3) begin failures++; $display("FAIL wd_e5_cycles got=%0d exp=3", w_rd_cycles); end
    checks++; if (w_total !== 32'd99) begin failures++; $display("FAIL wd_total_hold got=%0d exp=99", w_total); end
    pulse_start();
    checks++; if (w_timeout !== 1'b0) begin failures++; $display("FAIL wd_restart_tout got=%0h exp=0", w_timeout); end
    checks++; if (w_err !== 3'b000) begin failures++; $display("FAIL wd_restart_err got=%0h exp=0", w_err); end
    checks++; if (w_total !== 32'd0) begin failures++; $display("FAIL wd_restart_total got=%0d exp=0", w_total); end
    checks++; if (d_total !== 32'd102) begin failures++; $display("FAIL run_start_ignored got=%0d exp=102", d_total); end
    checks++; if (d_err !== 3'b010) begin failures++; $display("FAIL run_start_err got=%0h exp=2", d_err); end
    read_req(6'd5);
    checks++; if (w_rd_hit !== 1'b0) begin failures++; $display("FAIL wd_restart_e5 got=%0h exp=0", w_rd_hit); end
    pulse_net_done();
  endtask

  task automatic test_saturation();
    pulse_start();
    begin_layer(6'd7, 3'd4);
    step(19);
    end_layer();
    checks++; if (s_total !== 4'd15) begin failures++; $display("FAIL sat_total got=%0d exp=15", s_total); end
    checks++; if (d_total !== 32'd21) begin failures++; $display("FAIL sat_dflt_total got=%0d exp=21", d_total); end
    read_req(6'd7);
    checks++; if (s_rd_hit !== 1'b1) begin failures++; $display("FAIL sat_hit got=%0h exp=1", s_rd_hit); end
    checks++; if (s_rd_cycles !== 4'd15) begin failures++; $display("FAIL sat_cycles got=%0d exp=15", s_rd_cycles); end
    checks++; if (s_rd_type !== 3'd4) begin failures++; $display("FAIL sat_type got=%0d exp=4", s_rd_type); end
    checks++; if (d_rd_cycles !== 32'd20) begin failures++; $display("FAIL sat_dflt_cycles got=%0d exp=20", d_rd_cycles); end
    pulse_net_done();
    checks++; if (s_total !== 4'd15) begin failures++; $display("FAIL sat_total_done got=%0d exp=15", s_total); end
    checks++; if (s_finished !== 1'b1) begin failures++; $display("FAIL sat_finished got=%0h exp=1", s_finished); end
  endtask

  task automatic test_async_reset();
    pulse_start();
    begin_layer(6'd1, 3'd2);
    step(2);
    end_layer();
    begin_layer(6'd2, 3'd0);
    step(2);
    read_req(6'd1);
    checks++; if (d_rd_hit !== 1'b1) begin failures++; $display("FAIL ar_pre_hit got=%0h exp=1", d_rd_hit); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (d_busy !== 1'b0) begin failures++; $display("FAIL ar_busy got=%0h exp=0", d_busy); end
    checks++; if (d_total !== 32'd0) begin failures++; $display("FAIL ar_total got=%0d exp=0", d_total); end
    checks++; if (d_rd_valid !== 1'b0) begin failures++; $display("FAIL ar_rd_valid got=%0h exp=0", d_rd_valid); end
    checks++; if (d_rd_hit !== 1'b0) begin failures++; $display("FAIL ar_rd_hit got=%0h exp=0", d_rd_hit); end
    checks++; if (d_rd_cycles !== 32'd0) begin failures++; $display("FAIL ar_rd_cycles got=%0d exp=0", d_rd_cycles); end
    checks++; if (d_err !== 3'b000) begin failures++; $display("FAIL ar_err got=%0h exp=0", d_err); end
    #2 rst_n = 1'b1;
    step(1);
    read_req(6'd1);
    checks++; if (d_rd_hit !== 1'b0) begin failures++; $display("FAIL ar_e1_hit got=%0h exp=0", d_rd_hit); end
    read_req(6'd2);
    checks++; if (d_rd_hit !== 1'b0) begin failures++; $display("FAIL ar_e2_hit got=%0h exp=0", d_rd_hit); end
    checks++; if (d_busy !== 1'b0) begin failures++; $display("FAIL ar_idle got=%0h exp=0", d_busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_errors();
    test_watchdog();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
